// File: rtl/matrix_display_mode_pkg.sv
// Shared constants, state encoding and small helpers for the matrix display mode.
package matrix_display_mode_pkg;

  localparam int ELEMENT_WIDTH_DEF   = 16;
  localparam int BRAM_ADDR_WIDTH_DEF = 10;

  localparam logic [3:0] ERR_NONE       = 4'h0;
  localparam logic [3:0] ERR_SLOT_EMPTY = 4'h2;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  // Cycles between a tx_start decision and the next tx_busy sample: one for
  // the registered pulse itself and one gap cycle so a late busy is seen.
  localparam logic [1:0] TX_GAP = 2'd2;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_SLOT = 4'd1,
    QUERY     = 4'd2,
    SEND_HDR  = 4'd3,
    READ_REQ  = 4'd4,
    READ_WAIT = 4'd5,
    SEND_DIG  = 4'd6,
    SEND_SEP  = 4'd7,
    DONE      = 4'd8,
    ERROR     = 4'd9
  } state_t;

  function automatic logic is_dec_char(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= (ASCII_0 + 8'd9));
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return ASCII_0 + {4'd0, d};
  endfunction

endpackage

// File: rtl/matrix_display_mode_if.sv
// Bundle of UART, matrix-manager query and BRAM read signals used by the display mode.
interface matrix_display_mode_if
  import matrix_display_mode_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH_DEF
);
  logic                     mode_active;
  logic [7:0]               rx_data;
  logic                     rx_done;
  logic                     clear_rx_buffer;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic                     query_req;
  logic [3:0]               query_slot;
  logic                     query_valid;
  logic [3:0]               query_m;
  logic [3:0]               query_n;
  logic [ADDR_WIDTH-1:0]    query_addr;
  logic                     mem_rd_en;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr;
  logic [ELEMENT_WIDTH-1:0] mem_rd_data;
  logic [3:0]               error_code;
  logic [3:0]               sub_state;

  // The display mode drives requests and UART bytes.
  modport master (
    input  mode_active, rx_data, rx_done, tx_busy,
           query_valid, query_m, query_n, query_addr, mem_rd_data,
    output clear_rx_buffer, tx_data, tx_start, query_req, query_slot,
           mem_rd_en, mem_rd_addr, error_code, sub_state
  );

  // The surrounding system: UART, matrix manager and BRAM.
  modport slave (
    output mode_active, rx_data, rx_done, tx_busy,
           query_valid, query_m, query_n, query_addr, mem_rd_data,
    input  clear_rx_buffer, tx_data, tx_start, query_req, query_slot,
           mem_rd_en, mem_rd_addr, error_code, sub_state
  );
endinterface

// File: rtl/matrix_display_mode_bin8_to_dec.sv
// Combinational 8-bit binary to three BCD digits plus significant-digit count (1..3).
module matrix_display_mode_bin8_to_dec (
  input  logic [7:0] value,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] digit_count
);
  logic [7:0] rem;
  logic [8:0] tens_ge;

  assign hundreds = (value >= 8'd200) ? 4'd2 :
                    (value >= 8'd100) ? 4'd1 : 4'd0;
  assign rem      = value - 8'(hundreds) * 8'd100;

  // One comparator per tens threshold; their population count is the tens digit.
  for (genvar gi = 0; gi < 9; gi++) begin : g_tens
    assign tens_ge[gi] = (rem >= 8'((gi + 1) * 10));
  end

  // Count how many tens thresholds the remainder reaches.
  always_comb begin
    tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      tens = tens + {3'd0, tens_ge[k]};
    end
  end

  assign ones        = 4'(rem - 8'(tens) * 8'd10);
  assign digit_count = (hundreds != 4'd0) ? 2'd3 :
                       (tens != 4'd0)     ? 2'd2 : 2'd1;
endmodule

// File: rtl/matrix_display_mode.sv
// Reads a slot number over UART, looks the slot up, and prints its matrix as ASCII.
module matrix_display_mode
  import matrix_display_mode_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_display_mode_if.master bus
);
  state_t                  state_reg, state_next;
  logic                    tx_start_reg, tx_start_next;
  logic [7:0]              tx_data_reg, tx_data_next;
  logic                    clear_reg, clear_next;
  logic                    query_req_reg, query_req_next;
  logic [3:0]              query_slot_reg, query_slot_next;
  logic                    mem_rd_en_reg, mem_rd_en_next;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_reg, mem_rd_addr_next;
  logic [3:0]              error_reg, error_next;
  logic [3:0]              m_reg, m_next;
  logic [3:0]              n_reg, n_next;
  logic [ADDR_WIDTH-1:0]   base_reg, base_next;
  logic [7:0]              total_reg, total_next;
  logic [7:0]              idx_reg, idx_next;
  logic [3:0]              col_reg, col_next;
  logic [7:0]              value_reg, value_next;
  logic [1:0]              hdr_ptr_reg, hdr_ptr_next;
  logic [1:0]              dig_ptr_reg, dig_ptr_next;
  logic [1:0]              gap_reg, gap_next;
  logic                    rd_valid_reg;

  logic [ELEMENT_WIDTH-1:0] rd_word;
  logic                     unused_rd;
  logic [3:0]               dig_h, dig_t, dig_o, dig_val;
  logic [1:0]               dig_count, dig_sel;
  logic [7:0]               hdr_byte;
  logic                     can_send;

  assign rd_word   = bus.mem_rd_data;
  assign unused_rd = ^rd_word;

  matrix_display_mode_bin8_to_dec u_bin8_to_dec (
    .value       (value_reg),
    .hundreds    (dig_h),
    .tens        (dig_t),
    .ones        (dig_o),
    .digit_count (dig_count)
  );

  // Leading zeros are skipped by starting the pointer offset at the first significant digit.
  assign dig_sel  = 2'd3 - dig_count + dig_ptr_reg;
  assign can_send = !bus.tx_busy && (gap_reg == 2'd0);

  // Pick the digit addressed by the 2-bit pointer.
  always_comb begin
    unique case (dig_sel)
      2'd0:    dig_val = dig_h;
      2'd1:    dig_val = dig_t;
      default: dig_val = dig_o;
    endcase
  end

  // Header bytes: "m", space, "n", line feed.
  always_comb begin
    unique case (hdr_ptr_reg)
      2'd0:    hdr_byte = to_ascii(m_reg);
      2'd1:    hdr_byte = ASCII_SP;
      2'd2:    hdr_byte = to_ascii(n_reg);
      default: hdr_byte = ASCII_LF;
    endcase
  end

  // Next-state and next-output logic; all pulses default low, data fields hold.
  always_comb begin
    state_next       = state_reg;
    tx_start_next    = 1'b0;
    tx_data_next     = tx_data_reg;
    clear_next       = 1'b0;
    query_req_next   = 1'b0;
    query_slot_next  = query_slot_reg;
    mem_rd_en_next   = 1'b0;
    mem_rd_addr_next = mem_rd_addr_reg;
    error_next       = error_reg;
    m_next           = m_reg;
    n_next           = n_reg;
    base_next        = base_reg;
    total_next       = total_reg;
    idx_next         = idx_reg;
    col_next         = col_reg;
    value_next       = value_reg;
    hdr_ptr_next     = hdr_ptr_reg;
    dig_ptr_next     = dig_ptr_reg;
    gap_next         = (gap_reg != 2'd0) ? gap_reg - 2'd1 : 2'd0;

    if (!bus.mode_active) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: state_next = WAIT_SLOT;
        WAIT_SLOT: begin
          // clear_reg guards against consuming the same byte twice while rx_done falls.
          if (bus.rx_done && !clear_reg) begin
            clear_next = 1'b1;
            if (is_dec_char(bus.rx_data)) begin
              query_slot_next = bus.rx_data[3:0];
              error_next      = ERR_NONE;
              query_req_next  = 1'b1;
              state_next      = QUERY;
            end
          end
        end
        QUERY: begin
          if (bus.query_valid) begin
            m_next     = bus.query_m;
            n_next     = bus.query_n;
            base_next  = bus.query_addr;
            total_next = 8'(bus.query_m) * 8'(bus.query_n);
            if (bus.query_m == 4'd0 || bus.query_n == 4'd0) begin
              state_next = ERROR;
            end else begin
              hdr_ptr_next = 2'd0;
              state_next   = SEND_HDR;
            end
          end else begin
            query_req_next = 1'b1;
          end
        end
        SEND_HDR: begin
          if (can_send) begin
            tx_start_next = 1'b1;
            tx_data_next  = hdr_byte;
            gap_next      = TX_GAP;
            if (hdr_ptr_reg == 2'd3) begin
              idx_next   = 8'd0;
              col_next   = 4'd0;
              state_next = READ_REQ;
            end else begin
              hdr_ptr_next = hdr_ptr_reg + 2'd1;
            end
          end
        end
        READ_REQ: begin
          mem_rd_en_next   = 1'b1;
          mem_rd_addr_next = base_reg + ADDR_WIDTH'(idx_reg);
          state_next       = READ_WAIT;
        end
        READ_WAIT: begin
          // rd_valid_reg marks the cycle the BRAM output reflects our strobe.
          if (rd_valid_reg) begin
            value_next   = rd_word[7:0];
            dig_ptr_next = 2'd0;
            state_next   = SEND_DIG;
          end
        end
        SEND_DIG: begin
          if (can_send) begin
            tx_start_next = 1'b1;
            tx_data_next  = to_ascii(dig_val);
            gap_next      = TX_GAP;
            if (dig_ptr_reg == dig_count - 2'd1) begin
              state_next = SEND_SEP;
            end else begin
              dig_ptr_next = dig_ptr_reg + 2'd1;
            end
          end
        end
        SEND_SEP: begin
          if (can_send) begin
            tx_start_next = 1'b1;
            tx_data_next  = (col_reg == n_reg - 4'd1) ? ASCII_LF : ASCII_SP;
            gap_next      = TX_GAP;
            if (idx_reg == total_reg - 8'd1) begin
              state_next = DONE;
            end else begin
              idx_next   = idx_reg + 8'd1;
              col_next   = (col_reg == n_reg - 4'd1) ? 4'd0 : col_reg + 4'd1;
              state_next = READ_REQ;
            end
          end
        end
        DONE: state_next = IDLE;
        ERROR: begin
          error_next = ERR_SLOT_EMPTY;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= 8'd0;
      clear_reg       <= 1'b0;
      query_req_reg   <= 1'b0;
      query_slot_reg  <= 4'd0;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_addr_reg <= '0;
      error_reg       <= ERR_NONE;
      m_reg           <= 4'd0;
      n_reg           <= 4'd0;
      base_reg        <= '0;
      total_reg       <= 8'd0;
      idx_reg         <= 8'd0;
      col_reg         <= 4'd0;
      value_reg       <= 8'd0;
      hdr_ptr_reg     <= 2'd0;
      dig_ptr_reg     <= 2'd0;
      gap_reg         <= 2'd0;
      rd_valid_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tx_start_reg    <= tx_start_next;
      tx_data_reg     <= tx_data_next;
      clear_reg       <= clear_next;
      query_req_reg   <= query_req_next;
      query_slot_reg  <= query_slot_next;
      mem_rd_en_reg   <= mem_rd_en_next;
      mem_rd_addr_reg <= mem_rd_addr_next;
      error_reg       <= error_next;
      m_reg           <= m_next;
      n_reg           <= n_next;
      base_reg        <= base_next;
      total_reg       <= total_next;
      idx_reg         <= idx_next;
      col_reg         <= col_next;
      value_reg       <= value_next;
      hdr_ptr_reg     <= hdr_ptr_next;
      dig_ptr_reg     <= dig_ptr_next;
      gap_reg         <= gap_next;
      rd_valid_reg    <= mem_rd_en_reg;
    end
  end

  assign bus.tx_start        = tx_start_reg;
  assign bus.tx_data         = tx_data_reg;
  assign bus.clear_rx_buffer = clear_reg;
  assign bus.query_req       = query_req_reg;
  assign bus.query_slot      = query_slot_reg;
  assign bus.mem_rd_en       = mem_rd_en_reg;
  assign bus.mem_rd_addr     = mem_rd_addr_reg;
  assign bus.error_code      = error_reg;
  assign bus.sub_state       = state_reg;
endmodule
